// File: rtl/ecpri_pkg.sv
// Shared definitions for the eCPRI RAM arbiter: FSM state encoding,
// requester ids and default widths.
package ecpri_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 16;

  localparam logic REQ_RX = 1'b0;
  localparam logic REQ_TX = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OWN_0,
    ST_OWN_1,
    ST_TURN
  } arb_state_e;
endpackage

// File: rtl/ecpri_rr_sel.sv
// 2-way round-robin pick: a lone requester wins, a tie goes to whoever
// was not served last.
module ecpri_rr_sel
  import ecpri_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       any,
  output logic       pick
);
  assign any  = |req;
  assign pick = (&req) ? ((last_owner == REQ_RX) ? REQ_TX : REQ_RX) : req[REQ_TX];
endmodule

// File: rtl/ecpri_ram_arb.sv
// Arbitrates the eCPRI rx/tx requesters onto one single-port SRAM port with
// burst limiting, a one-cycle turnaround and tagged two-cycle read returns.
module ecpri_ram_arb
  import ecpri_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MAX_BURST  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_0,
  input  logic                  req_1,
  input  logic [ADDR_WIDTH-1:0] addr_0,
  input  logic [ADDR_WIDTH-1:0] addr_1,
  input  logic [DATA_WIDTH-1:0] wdata_0,
  input  logic [DATA_WIDTH-1:0] wdata_1,
  input  logic                  we_0,
  input  logic                  we_1,
  output logic                  gnt_0,
  output logic                  gnt_1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid_0,
  output logic                  rvalid_1,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);
  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);
  localparam int STAGES = 1;

  arb_state_e            state;
  logic                  last_owner;
  logic [CW-1:0]         burst_cnt, cnt_nxt;
  logic                  issue_0, issue_1, issue, rd_issue;
  logic                  sel_any, sel_pick;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STAGES:0]       vld_pipe, id_pipe;

  assign issue_0  = gnt_0 & req_0;
  assign issue_1  = gnt_1 & req_1;
  assign issue    = issue_0 | issue_1;
  assign rd_issue = issue & ~ram_we;

  // Count including the current cycle so the owner releases after exactly
  // MAX_BURST issued cycles when the other side is waiting.
  assign cnt_nxt = (issue && burst_cnt != BURST_MAX) ? burst_cnt + 1'b1 : burst_cnt;

  ecpri_rr_sel u_rr_sel (
    .req        ({req_1, req_0}),
    .last_owner (last_owner),
    .any        (sel_any),
    .pick       (sel_pick)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      gnt_0      <= 1'b0;
      gnt_1      <= 1'b0;
      burst_cnt  <= '0;
      last_owner <= REQ_TX;
    end else begin
      unique case (state)
        ST_IDLE, ST_TURN: begin
          burst_cnt <= '0;
          gnt_0     <= sel_any && (sel_pick == REQ_RX);
          gnt_1     <= sel_any && (sel_pick == REQ_TX);
          if (!sel_any)                 state <= ST_IDLE;
          else if (sel_pick == REQ_TX)  state <= ST_OWN_1;
          else                          state <= ST_OWN_0;
        end
        ST_OWN_0: begin
          burst_cnt <= cnt_nxt;
          if (!req_0 || (req_1 && cnt_nxt == BURST_MAX)) begin
            state      <= ST_TURN;
            gnt_0      <= 1'b0;
            last_owner <= REQ_RX;
          end
        end
        ST_OWN_1: begin
          burst_cnt <= cnt_nxt;
          if (!req_1 || (req_0 && cnt_nxt == BURST_MAX)) begin
            state      <= ST_TURN;
            gnt_1      <= 1'b0;
            last_owner <= REQ_TX;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Address/data hold their last issued value while the port is idle.
  always_comb begin
    ram_cs    = issue;
    ram_we    = 1'b0;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    if (issue) begin
      ram_we    = issue_1 ? we_1    : we_0;
      ram_addr  = issue_1 ? addr_1  : addr_0;
      ram_wdata = issue_1 ? wdata_1 : wdata_0;
    end
  end

  assign ram_oe = ~ram_we;

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (issue) begin
      addr_q  <= ram_addr;
      wdata_q <= ram_wdata;
    end
  end

  // Read return pipe: the issuing id rides along so returns land on the
  // right requester even after the grant has moved.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
      rdata    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], rd_issue};
      id_pipe  <= {id_pipe[STAGES-1:0], issue_1};
      if (vld_pipe[STAGES-1]) rdata <= ram_rdata;
    end
  end

  assign rvalid_0 = vld_pipe[STAGES] & (id_pipe[STAGES] == REQ_RX);
  assign rvalid_1 = vld_pipe[STAGES] & (id_pipe[STAGES] == REQ_TX);
endmodule

// File: tb/tb_ecpri_ram_arb.sv
// Randomized + directed bench for ecpri_ram_arb: a behavioural arbitration
// model predicts grants and port activity, a scoreboard checks read returns.
module tb_ecpri_ram_arb;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam int MB = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_0, req_1, we_0, we_1;
  logic [AW-1:0] addr_0, addr_1;
  logic [DW-1:0] wdata_0, wdata_1;
  logic          gnt_0, gnt_1, rvalid_0, rvalid_1;
  logic [DW-1:0] rdata, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_cs, ram_we, ram_oe;

  ecpri_ram_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .req_0(req_0), .req_1(req_1), .addr_0(addr_0), .addr_1(addr_1),
    .wdata_0(wdata_0), .wdata_1(wdata_1), .we_0(we_0), .we_1(we_1),
    .gnt_0(gnt_0), .gnt_1(gnt_1), .rdata(rdata),
    .rvalid_0(rvalid_0), .rvalid_1(rvalid_1),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_cs(ram_cs),
    .ram_we(ram_we), .ram_oe(ram_oe), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0, n_chk = 0, n_pass = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous SRAM: read data appears the cycle after the address.
  logic [DW-1:0] mem     [0:65535];
  logic [DW-1:0] ref_mem [0:65535];
  always @(posedge clk) begin
    if (ram_cs && ram_we)  mem[ram_addr] <= ram_wdata;
    if (ram_cs && !ram_we) ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    else n_pass++;
  endtask

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: who owns the port, how long it has streamed, who went last.
  int            m_owner = -1, m_last = 1, m_streak = 0;
  bit            m_turn = 0, m_on = 0, rst_seen = 0, iss;
  logic          rq [2];
  logic [AW-1:0] m_addr, ia;
  logic [DW-1:0] m_wd, idt;
  logic          iw;

  task automatic pick();
    if (rq[0] && rq[1]) m_owner = 1 - m_last;
    else if (rq[0])     m_owner = 0;
    else if (rq[1])     m_owner = 1;
    m_streak = 0;
  endtask

  always @(negedge clk) begin
    rq[0] = req_0;
    rq[1] = req_1;
    iss   = 0;
    if (m_on) begin
      chk("gnt_0", gnt_0, m_owner == 0);
      chk("gnt_1", gnt_1, m_owner == 1);
      if (m_owner >= 0) iss = rq[m_owner];
      ia  = (m_owner == 1) ? addr_1  : addr_0;
      iw  = (m_owner == 1) ? we_1    : we_0;
      idt = (m_owner == 1) ? wdata_1 : wdata_0;
      chk("ram_cs", ram_cs, iss);
      chk("ram_we", ram_we, iss && iw);
      chk("ram_oe", ram_oe, !(iss && iw));
      if (iss) begin
        chk("ram_addr", ram_addr, ia);
        chk("ram_wdata", ram_wdata, idt);
        m_addr = ia;
        m_wd   = idt;
        if (iw) ref_mem[ia] = idt;
        else if (reset) exp_q.push_back('{m_owner, ref_mem[ia], cyc + 2});
      end else begin
        chk("ram_addr_hold", ram_addr, m_addr);
        chk("ram_wdata_hold", ram_wdata, m_wd);
      end
      if (rst_seen) begin
        chk("rdata_reset", rdata, 0);
        rst_seen = 0;
      end
    end
    if (!reset) begin
      m_on = 1; m_owner = -1; m_turn = 0; m_last = 1; m_streak = 0;
      m_addr = '0; m_wd = '0; rst_seen = 1;
    end else if (m_owner >= 0) begin
      if (iss) m_streak++;
      if (!rq[m_owner] || (rq[1 - m_owner] && m_streak >= MB)) begin
        m_last  = m_owner;
        m_owner = -1;
        m_turn  = 1;
      end
    end else if (m_turn) begin
      m_turn = 0;
      pick();
    end else begin
      pick();
    end
  end

  // Scoreboard monitor: every expected return must show up exactly on time.
  exp_t e;
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        chk("rvalid_0", rvalid_0, e.id == 0);
        chk("rvalid_1", rvalid_1, e.id == 1);
        chk("rdata", rdata, e.data);
      end else if (rvalid_0 || rvalid_1) begin
        chk("spurious_rvalid", {rvalid_1, rvalid_0}, 0);
      end
      if (!reset) exp_q.delete();
    end
  end

  task automatic drive(input logic r0, input logic r1, input logic w0, input logic w1,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    req_0 = r0; req_1 = r1; we_0 = w0; we_1 = w1;
    addr_0 = a0; addr_1 = a1; wdata_0 = d0; wdata_1 = d1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, '0, '0, '0, '0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = i[7:0] ^ 8'h3C;
      ref_mem[i] = i[7:0] ^ 8'h3C;
    end
    for (int i = 0; i < 4; i++) begin
      mem[i]     = 8'hA0 + 8'(i);
      ref_mem[i] = 8'hA0 + 8'(i);
    end
    reset = 1'b0;
    idle(3);
    reset = 1'b1;

    // rx alone reads the preloaded 0xA0..0xA3
    drive(1, 0, 0, 0, 16'd0, '0, '0, '0);
    for (int k = 0; k < 4; k++) drive(1, 0, 0, 0, AW'(k), '0, '0, '0);
    idle(4);

    // simultaneous requests straight after reset: rx first, then tx after a turn
    do_reset();
    for (int k = 0; k < 6; k++) drive(1, 1, 0, 0, AW'($urandom_range(0, 255)), AW'($urandom_range(0, 255)), '0, '0);
    for (int k = 0; k < 5; k++) drive(0, 1, 0, 0, '0, AW'($urandom_range(0, 255)), '0, '0);
    idle(3);

    // long rx burst with tx waiting from cycle 5: burst limit and turn-time read return
    for (int k = 0; k < 100; k++) drive(1, k >= 5, 0, 0, AW'(k + 200), AW'(k + 400), '0, '0);
    idle(4);

    // tx writes 0x5A to 0x0010, rx reads it back
    drive(0, 1, 0, 1, '0, 16'h0010, '0, 8'h5A);
    drive(0, 1, 0, 1, '0, 16'h0010, '0, 8'h5A);
    idle(2);
    for (int k = 0; k < 3; k++) drive(1, 0, 0, 0, 16'h0010, '0, '0, '0);
    idle(4);

    // reset lands while tx owns the port with reads in flight
    for (int k = 0; k < 4; k++) drive(0, 1, 0, 0, '0, AW'(k + 8), '0, '0);
    reset = 1'b0;
    drive(0, 1, 0, 0, '0, 16'd12, '0, '0);
    reset = 1'b1;
    idle(4);

    // random traffic over a small address window so reads hit earlier writes
    for (int k = 0; k < 400; k++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)),
            DW'($urandom), DW'($urandom));
    idle(6);

    chk("pending_reads", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ecpri_ram_arb.md
ECPRI_RAM_ARB -- requirements
Module: ecpri_ram_arb

Interface
REQ-001 Parameter DATA_WIDTH, default 8, RAM data width.
REQ-002 Parameter ADDR_WIDTH, default 16, RAM address width.
REQ-003 Parameter MAX_BURST, default 64, max consecutive granted cycles while the other requester waits.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 req_0/req_1  input  1 each  access request; requester 0 = ecpri_rx, requester 1 = ecpri_tx.
REQ-007 addr_0/addr_1  input  ADDR_WIDTH each  requester address.
REQ-008 wdata_0/wdata_1  input  DATA_WIDTH each  requester write data.
REQ-009 we_0/we_1  input  1 each  1 = write, 0 = read.
REQ-010 gnt_0/gnt_1  output  1 each  owner indication; a requester's access is issued only in cycles where its gnt and req are both 1.
REQ-011 rdata  output  DATA_WIDTH  registered read data.
REQ-012 rvalid_0/rvalid_1  output  1 each  rdata valid for that requester.
REQ-013 ram_addr  output  ADDR_WIDTH, ram_wdata  output  DATA_WIDTH, ram_cs/ram_we/ram_oe  output  1, ram_rdata  input  DATA_WIDTH -- one ram_dp_sr_sw port; ram_oe active-low drive enable as the RAM expects.

Function
REQ-014 FSM states: IDLE, OWN_0, OWN_1, TURN; state encoding from shared package.
REQ-015 IDLE: req_0 only -> OWN_0; req_1 only -> OWN_1; both -> requester not served last (last_owner flag; after reset requester 0 wins).
REQ-016 OWN_n: gnt_n=1; stays while req_n=1 and (other req=0 or burst_cnt < MAX_BURST).
REQ-017 OWN_n exit: req_n=0, or burst_cnt == MAX_BURST with other req=1 -> TURN; last_owner <= n.
REQ-018 TURN: exactly one cycle, both gnt=0, ram_cs=0; then grant per REQ-015 rules.
REQ-019 Grant is registered: gnt changes only on clock edges; at most one gnt high ever.
REQ-020 burst_cnt: clears on entry to OWN_n, increments each cycle req_n && gnt_n, saturates at MAX_BURST; width clog2(MAX_BURST)+1.
REQ-021 Issued access (gnt_n && req_n): ram_cs=1, ram_addr=addr_n, ram_we=we_n, ram_wdata=wdata_n, ram_oe=~we_n... write drives oe=0, read oe=1; combinational mux from owner.
REQ-022 No issued access: ram_cs=0, ram_we=0, ram_oe=1, ram_addr/ram_wdata hold last value.
REQ-023 Read latency 2: read issued cycle N -> RAM data cycle N+1 -> rdata registered, rvalid_n=1 in cycle N+2, one pulse per read.
REQ-024 Read pipeline tag (owner id) travels with the read; reads in flight complete after grant moves, rvalid goes to issuing requester.
REQ-025 Writes produce no rvalid.
REQ-026 Requester dropping req mid-burst in OWN_n: that cycle is not issued; FSM to TURN next edge.

Reset
REQ-027 reset=0 at posedge: state IDLE, gnt_0=gnt_1=0, rvalid_0=rvalid_1=0, rdata=0, burst_cnt=0, last_owner=1, read pipeline flushed; ram_cs=0, ram_we=0, ram_oe=1, ram_addr=0, ram_wdata=0.
REQ-028 Reset mid-burst aborts in-flight reads; no rvalid after reset.

Structure
REQ-029 Package ecpri_pkg holds FSM state typedef, requester id constants, DATA_WIDTH/ADDR_WIDTH defaults.
REQ-030 One sub-module: ecpri_rr_sel (2-way round-robin pick from req vector and last_owner); rest flat.

Verification
REQ-031 req_0 alone, 4 reads addr 0..3 of preloaded 0xA0..0xA3 -> gnt_0 1 cycle after req, rvalid_0 with 0xA0..0xA3, 2 cycles after each issue.
REQ-032 req_0 and req_1 same cycle after reset -> gnt_0 first; on req_0 drop, one TURN cycle, then gnt_1.
REQ-033 req_0 held 100 cycles, req_1 asserted at cycle 5 -> gnt_0 released after exactly 64 issued cycles, TURN, gnt_1 granted.
REQ-034 req_1 write 0x5A to addr 0x0010, then req_0 read 0x0010 -> rvalid_0 with rdata 0x5A; ram_oe=0 only on write cycle.
REQ-035 Read issued last cycle of OWN_0 -> rvalid_0 (not rvalid_1) two cycles later during TURN/OWN_1.
REQ-036 reset=0 during OWN_1 with read in flight -> next cycle all outputs at REQ-027 values, no rvalid.
